// File: rtl/mem_cache_sa.sv
// mem_cache_sa: set-associative (1 or 2 way) write-back, write-allocate data cache, one word per line.
// Define CACHE_STATS_EN to add the hit_count/miss_count outputs.
module mem_cache_sa #(
    parameter int XLEN        = 32,
    parameter int SETS        = 8,
    parameter int WAYS        = 1,
    parameter int MEM_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic            req_byte,
    input  logic [XLEN-1:0] addr,
    input  logic [7:0]      data_in [0:3],
    output logic [7:0]      data_out [0:3],
    output logic            ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [7:0]      mem_data_in [0:3],
    input  logic [7:0]      mem_data_out [0:3],
    output logic            mem_write_en,
    output logic [1:0]      state_dbg
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
`endif
);

    localparam int INDEX_BITS = $clog2(SETS);
    localparam int TAG_BITS   = XLEN - INDEX_BITS - 2;
    localparam int CNT_W      = $clog2(MEM_LATENCY) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WB   = 2'd1;
    localparam logic [1:0] FILL = 2'd2;

    if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
        $error("mem_cache_sa: WAYS must be 1 or 2");
    end

    // Storage is always two ways wide; way 1 is never hit or chosen when WAYS == 1.
    logic [SETS-1:0]     valid_q [0:1];
    logic [SETS-1:0]     dirty_q [0:1];
    logic [SETS-1:0]     lru_q;
    logic [TAG_BITS-1:0] tag_q   [0:1][SETS];
    logic [7:0]          data_q  [0:1][SETS][0:3];

    logic [1:0]            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  victim_q;
    logic [XLEN-3:0]       miss_word_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0]   miss_tag;
    logic                  hit0;
    logic                  hit1;
    logic                  hit;
    logic                  hit_way;
    logic                  victim;
    logic                  victim_dirty;

    assign idx      = addr[INDEX_BITS+1:2];
    assign tag      = addr[XLEN-1:INDEX_BITS+2];
    assign miss_idx = miss_word_q[INDEX_BITS-1:0];
    assign miss_tag = miss_word_q[XLEN-3:INDEX_BITS];

    assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1    = (WAYS == 2) && valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;

    // Handshake: req_valid and all request fields stay stable until ready; ready is a
    // same-cycle hit in IDLE and the access (store write / LRU update) commits on that edge.
    assign ready        = req_valid && (state_q == IDLE) && hit;
    assign mem_write_en = (state_q == WB);
    assign state_dbg    = state_q;

    always_comb begin
        if (!valid_q[0][idx]) begin
            victim = 1'b0;
        end else if ((WAYS == 2) && !valid_q[1][idx]) begin
            victim = 1'b1;
        end else if (WAYS == 2) begin
            victim = lru_q[idx];
        end else begin
            victim = 1'b0;
        end
        victim_dirty = valid_q[victim][idx] && dirty_q[victim][idx];
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            data_out[i] = 8'd0;
        end
        if (ready && !req_we) begin
            if (req_byte) begin
                data_out[0] = data_q[hit_way][idx][addr[1:0]];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    data_out[i] = data_q[hit_way][idx][i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            victim_q    <= 1'b0;
            miss_word_q <= '0;
            mem_addr    <= '0;
            for (int i = 0; i < 4; i++) begin
                mem_data_in[i] <= 8'd0;
            end
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ready) begin
                        if (req_we) begin
                            dirty_q[hit_way][idx] <= 1'b1;
                        end
                        if (WAYS == 2) begin
                            lru_q[idx] <= ~hit_way;
                        end
                    end else if (req_valid) begin
                        // The miss address is latched so the fill completes even if the request is withdrawn.
                        victim_q    <= victim;
                        miss_word_q <= addr[XLEN-1:2];
                        cnt_q       <= CNT_W'(MEM_LATENCY - 1);
                        for (int i = 0; i < 4; i++) begin
                            mem_data_in[i] <= data_q[victim][idx][i];
                        end
                        if (victim_dirty) begin
                            state_q  <= WB;
                            mem_addr <= {tag_q[victim][idx], idx, 2'b00};
                        end else begin
                            state_q  <= FILL;
                            mem_addr <= {addr[XLEN-1:2], 2'b00};
                        end
                    end
                end
                WB: begin
                    if (cnt_q == '0) begin
                        dirty_q[victim_q][miss_idx] <= 1'b0;
                        state_q  <= FILL;
                        cnt_q    <= CNT_W'(MEM_LATENCY - 1);
                        mem_addr <= {miss_word_q, 2'b00};
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                FILL: begin
                    if (cnt_q == '0) begin
                        valid_q[victim_q][miss_idx] <= 1'b1;
                        dirty_q[victim_q][miss_idx] <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tags and data need no reset: the valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (ready && req_we) begin
            if (req_byte) begin
                data_q[hit_way][idx][addr[1:0]] <= data_in[0];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    data_q[hit_way][idx][i] <= data_in[i];
                end
            end
        end
        if ((state_q == FILL) && (cnt_q == '0)) begin
            for (int i = 0; i < 4; i++) begin
                data_q[victim_q][miss_idx][i] <= mem_data_out[i];
            end
            tag_q[victim_q][miss_idx] <= miss_tag;
        end
    end

`ifdef CACHE_STATS_EN
    // missed_q marks a request that already missed, so its post-fill hit is not counted.
    logic missed_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit_count  <= '0;
            miss_count <= '0;
            missed_q   <= 1'b0;
        end else if ((state_q == IDLE) && req_valid && !hit) begin
            miss_count <= miss_count + 32'd1;
            missed_q   <= 1'b1;
        end else if (ready) begin
            if (!missed_q) begin
                hit_count <= hit_count + 32'd1;
            end
            missed_q <= 1'b0;
        end else if ((state_q == IDLE) && !req_valid) begin
            missed_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_cache_sa.sv
// tb_mem_cache_sa: directed bench for mem_cache_sa; instance a is direct-mapped, instance b is 2-way.
// Expected load data and ready cycles go into a queue that a negedge monitor pops on every ready.
module tb_mem_cache_sa;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        rv_a;
    logic        rv_b;
    logic        req_we;
    logic        req_byte;
    logic [31:0] addr;
    logic [7:0]  data_in [0:3];

    logic [7:0]  dout_a [0:3];
    logic [7:0]  dout_b [0:3];
    logic        ready_a;
    logic        ready_b;
    logic [31:0] maddr_a;
    logic [31:0] maddr_b;
    logic [7:0]  mdin_a [0:3];
    logic [7:0]  mdin_b [0:3];
    logic [7:0]  mdout_a [0:3];
    logic [7:0]  mdout_b [0:3];
    logic        wen_a;
    logic        wen_b;
    logic [1:0]  st_a;
    logic [1:0]  st_b;
`ifdef CACHE_STATS_EN
    logic [31:0] hits_a;
    logic [31:0] misses_a;
    logic [31:0] hits_b;
    logic [31:0] misses_b;
`endif

    logic [31:0] mem [0:255];
    logic [31:0] dout_a_w;
    logic [31:0] dout_b_w;
    logic [31:0] mdin_a_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wen_cnt_a = 0;
    logic [31:0] wen_addr_a = '0;
    logic [31:0] wen_data_a = '0;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    logic        exp_ld_q[$];

    mem_cache_sa #(.XLEN(32), .SETS(8), .WAYS(1), .MEM_LATENCY(4)) u_a (
        .clk(clk), .rst_b(rst_b), .req_valid(rv_a), .req_we(req_we), .req_byte(req_byte),
        .addr(addr), .data_in(data_in), .data_out(dout_a), .ready(ready_a),
        .mem_addr(maddr_a), .mem_data_in(mdin_a), .mem_data_out(mdout_a),
        .mem_write_en(wen_a), .state_dbg(st_a)
`ifdef CACHE_STATS_EN
        , .hit_count(hits_a), .miss_count(misses_a)
`endif
    );

    mem_cache_sa #(.XLEN(32), .SETS(8), .WAYS(2), .MEM_LATENCY(4)) u_b (
        .clk(clk), .rst_b(rst_b), .req_valid(rv_b), .req_we(req_we), .req_byte(req_byte),
        .addr(addr), .data_in(data_in), .data_out(dout_b), .ready(ready_b),
        .mem_addr(maddr_b), .mem_data_in(mdin_b), .mem_data_out(mdout_b),
        .mem_write_en(wen_b), .state_dbg(st_b)
`ifdef CACHE_STATS_EN
        , .hit_count(hits_b), .miss_count(misses_b)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word-addressed backing memory shared by both caches
    assign dout_a_w = {dout_a[3], dout_a[2], dout_a[1], dout_a[0]};
    assign dout_b_w = {dout_b[3], dout_b[2], dout_b[1], dout_b[0]};
    assign mdin_a_w = {mdin_a[3], mdin_a[2], mdin_a[1], mdin_a[0]};
    assign mdout_a[0] = mem[maddr_a[9:2]][7:0];
    assign mdout_a[1] = mem[maddr_a[9:2]][15:8];
    assign mdout_a[2] = mem[maddr_a[9:2]][23:16];
    assign mdout_a[3] = mem[maddr_a[9:2]][31:24];
    assign mdout_b[0] = mem[maddr_b[9:2]][7:0];
    assign mdout_b[1] = mem[maddr_b[9:2]][15:8];
    assign mdout_b[2] = mem[maddr_b[9:2]][23:16];
    assign mdout_b[3] = mem[maddr_b[9:2]][31:24];

    always @(posedge clk) begin
        if (wen_a) mem[maddr_a[9:2]] <= mdin_a_w;
        if (wen_b) mem[maddr_b[9:2]] <= {mdin_b[3], mdin_b[2], mdin_b[1], mdin_b[0]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write-strobe monitor for instance a
    always @(negedge clk) begin
        if (wen_a) begin
            wen_cnt_a  <= wen_cnt_a + 1;
            wen_addr_a <= maddr_a;
            wen_data_a <= mdin_a_w;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_b && ((rv_a && ready_a) || (rv_b && ready_b))) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: ready with empty queue (cycle %0d)", cyc);
            end else begin
                logic [31:0] d;
                int          c;
                logic        ld;
                d  = exp_q.pop_front();
                c  = exp_cyc_q.pop_front();
                ld = exp_ld_q.pop_front();
                check("ready_cycle", cyc, c);
                if (ld) check("load_data", rv_a ? dout_a_w : dout_b_w, d);
            end
        end
    end

    // Driver: one access, expected data and latency (cycles from issue to ready)
    task automatic access(input bit inst, input bit we, input bit byt, input logic [31:0] a,
                          input logic [31:0] wdata, input logic [31:0] exp_data, input int lat);
        bit done;
        @(posedge clk);
        #1;
        addr       = a;
        req_we     = we;
        req_byte   = byt;
        data_in[0] = wdata[7:0];
        data_in[1] = wdata[15:8];
        data_in[2] = wdata[23:16];
        data_in[3] = wdata[31:24];
        exp_q.push_back(exp_data);
        exp_cyc_q.push_back(cyc + lat);
        exp_ld_q.push_back(!we);
        if (inst) rv_b = 1'b1;
        else rv_a = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (inst ? ready_b : ready_a) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: no ready for addr 0x%08h, expected within %0d cycles", a, lat);
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
                void'(exp_ld_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        rv_a = 1'b0;
        rv_b = 1'b0;
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[16] = 32'hDEADBEEF;  // 0x40
        mem[24] = 32'h11223344;  // 0x60
        mem[32] = 32'h55667788;  // 0x80
        rv_a = 1'b0;
        rv_b = 1'b0;
        req_we = 1'b0;
        req_byte = 1'b0;
        addr = '0;
        for (int i = 0; i < 4; i++) data_in[i] = 8'd0;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, ready_a}, 32'd0);
        check("reset_wen", {31'd0, wen_a}, 32'd0);
        check("reset_mem_addr", maddr_a, 32'd0);
        check("reset_data_out", dout_a_w, 32'd0);
        check("reset_state", {30'd0, st_a}, 32'd0);
        #1 rst_b = 1'b1;

        // Clean miss then hit
        access(0, 0, 0, 32'h40, 32'h0, 32'hDEADBEEF, 5);
        access(0, 0, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0);

        // Byte store hit, no memory traffic
        wen_cnt_a = 0;
        access(0, 1, 1, 32'h41, 32'h000000AA, 32'h0, 0);
        check("sb_no_wen", wen_cnt_a, 0);
        access(0, 0, 0, 32'h40, 32'h0, 32'hDEADAAEF, 0);
`ifdef CACHE_STATS_EN
        @(negedge clk);
        check("miss_count", misses_a, 32'd1);
        check("hit_count", hits_a, 32'd3);
`endif
        access(0, 0, 1, 32'h41, 32'h0, 32'h000000AA, 0);
        access(0, 0, 1, 32'h43, 32'h0, 32'h000000DE, 0);

        // Dirty eviction in the direct-mapped cache, then thrashing
        wen_cnt_a = 0;
        access(0, 0, 0, 32'h60, 32'h0, 32'h11223344, 9);
        check("wb_cycles", wen_cnt_a, 4);
        check("wb_addr", wen_addr_a, 32'h40);
        check("wb_data", wen_data_a, 32'hDEADAAEF);
        check("wb_mem", mem[16], 32'hDEADAAEF);
        access(0, 0, 0, 32'h40, 32'h0, 32'hDEADAAEF, 5);
        access(0, 0, 0, 32'h60, 32'h0, 32'h11223344, 5);

        // Two-way LRU victim selection
        access(1, 0, 0, 32'h40, 32'h0, 32'hDEADAAEF, 5);
        access(1, 0, 0, 32'h60, 32'h0, 32'h11223344, 5);
        access(1, 0, 0, 32'h40, 32'h0, 32'hDEADAAEF, 0);
        access(1, 0, 0, 32'h80, 32'h0, 32'h55667788, 5);
        access(1, 0, 0, 32'h40, 32'h0, 32'hDEADAAEF, 0);
        access(1, 0, 0, 32'h60, 32'h0, 32'h11223344, 5);

        // Reset during write-back
        access(0, 1, 0, 32'h60, 32'hCAFEF00D, 32'h0, 0);
        @(posedge clk);
        #1;
        addr = 32'h40;
        req_we = 1'b0;
        req_byte = 1'b0;
        rv_a = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (wen_a) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wb_start_timeout: mem_write_en never rose, expected 1");
        end
        @(posedge clk);
        #1;
        check("wb_cycle2_wen", {31'd0, wen_a}, 32'd1);
        rst_b = 1'b0;
        rv_a = 1'b0;
        #1;
        check("abort_wen", {31'd0, wen_a}, 32'd0);
        check("abort_state", {30'd0, st_a}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        check("abort_partial_wb", mem[24], 32'hCAFEF00D);
        access(0, 0, 0, 32'h40, 32'h0, 32'hDEADAAEF, 5);
        access(0, 0, 0, 32'h60, 32'h0, 32'hCAFEF00D, 5);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expect: %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
